// File: rtl/rv_pkg.sv
// Shared RV32 decode definitions: opcode constants, immediate formats and
// the IF/ID skid-buffer state encoding.
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} imm_fmt_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    function automatic imm_fmt_t imm_fmt(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32 immediate generator, sign-extended from bit 31 to XLEN.
// R-format and unknown opcodes yield zero.
module rv_imm_gen
    import rv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (imm_fmt(i_instr[6:0]))
            FMT_I: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S: w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B: w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                              i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U: w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                              i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a two-entry skid buffer and field/immediate decode.
// Optional IF_ID_TRACE_EN adds a simulation-only per-consume trace line.
module if_id_skid
    import rv_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr_in,
    input  logic [PC_W-1:0] pc_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     instr_out,
    output logic [PC_W-1:0] pc_out,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm
);

    state_t          r_state, w_next_state;
    logic            r_in_ready;
    logic [31:0]     r_main_instr, r_skid_instr;
    logic [PC_W-1:0] r_main_pc, r_skid_pc;
    logic            w_accept, w_consume;
    logic            w_load_main, w_load_skid, w_skid_to_main, w_clear_main;

    assign w_accept  = in_valid & r_in_ready;
    assign w_consume = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != TWO);
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (flush) begin
            w_next_state = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_accept) w_next_state = ONE;
                ONE: begin
                    if (w_accept && !w_consume)      w_next_state = TWO;
                    else if (!w_accept && w_consume) w_next_state = EMPTY;
                end
                TWO:   if (w_consume) w_next_state = ONE;
                default: w_next_state = EMPTY;
            endcase
        end
    end

    // Datapath enables; flush overrides every load so a same-cycle accept is dropped.
    always_comb begin
        w_load_main    = 1'b0;
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
        w_clear_main   = flush;
        if (!flush) begin
            case (r_state)
                EMPTY: w_load_main = w_accept;
                ONE: begin
                    w_load_main  = w_accept & w_consume;
                    w_load_skid  = w_accept & ~w_consume;
                    w_clear_main = ~w_accept & w_consume;
                end
                TWO:   w_skid_to_main = w_consume;
                default: w_clear_main = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_instr <= '0;
            r_main_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            if (w_clear_main) begin
                r_main_instr <= '0;
                r_main_pc    <= '0;
            end else if (w_load_main) begin
                r_main_instr <= instr_in;
                r_main_pc    <= pc_in;
            end else if (w_skid_to_main) begin
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid_instr <= instr_in;
                r_skid_pc    <= pc_in;
            end
        end
    end

    // Outputs are gated by valid so an empty stage always presents zeros.
    always_comb begin
        in_ready  = r_in_ready;
        out_valid = (r_state != EMPTY);
        instr_out = out_valid ? r_main_instr : '0;
        pc_out    = out_valid ? r_main_pc : '0;
    end

    assign opcode = instr_out[6:0];
    assign rd     = instr_out[11:7];
    assign funct3 = instr_out[14:12];
    assign rs1    = instr_out[19:15];
    assign rs2    = instr_out[24:20];
    assign funct7 = instr_out[31:25];

    rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instr (instr_out),
        .o_imm   (imm)
    );

`ifdef IF_ID_TRACE_EN
    always @(posedge clk) begin
        if (!rst && w_consume) begin
            case (imm_fmt(opcode))
                FMT_I: $display("if_id: I pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", pc_out, rd, rs1, rs2, $signed(imm));
                FMT_S: $display("if_id: S pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", pc_out, rd, rs1, rs2, $signed(imm));
                FMT_B: $display("if_id: B pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", pc_out, rd, rs1, rs2, $signed(imm));
                FMT_U: $display("if_id: U pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", pc_out, rd, rs1, rs2, $signed(imm));
                FMT_J: $display("if_id: J pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", pc_out, rd, rs1, rs2, $signed(imm));
                default: begin
                    if (opcode == OP_R)
                        $display("if_id: R pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", pc_out, rd, rs1, rs2, $signed(imm));
                    else
                        $display("if_id: op=%b pc=%h rd=%0d rs1=%0d rs2=%0d imm=%0d", opcode, pc_out, rd, rs1, rs2, $signed(imm));
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid.sv
// Directed self-checking bench for if_id_skid: decode, streaming, backpressure,
// flush and mid-stream reset, with hand-computed expectations.
module tb_if_id_skid;

    localparam int PC_W = 8;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]     instr_in, instr_out;
    logic [PC_W-1:0] pc_in, pc_out;
    logic [6:0]      opcode, funct7;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_id_skid #(.PC_W(PC_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_W-1:0] pc);
        in_valid = v;
        instr_in = ins;
        pc_in    = pc;
    endtask

    logic [31:0] imm_ins [5];
    logic [63:0] imm_exp [5];

    initial begin
        imm_ins[0] = 32'h12345037; imm_exp[0] = 64'h0000_0000_1234_5000; // lui
        imm_ins[1] = 32'h0100006F; imm_exp[1] = 64'd16;                  // jal +16
        imm_ins[2] = 32'h0020A423; imm_exp[2] = 64'd8;                   // sw x2,8(x1)
        imm_ins[3] = 32'h002081B3; imm_exp[3] = 64'd0;                   // add (R)
        imm_ins[4] = 32'h0000007F; imm_exp[4] = 64'd0;                   // unknown

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_instr",     64'(instr_out), 64'd0);
        chk("rst_pc",        64'(pc_out),    64'd0);
        chk("rst_imm",       imm,            64'd0);
        rst = 1'b0;
        tick();

        // addi x5,x0,-3
        drive(1'b1, 32'hFFD00293, 8'h04);
        tick();
        drive(1'b0, 32'h0, 8'h0);
        chk("addi_valid",  64'(out_valid), 64'd1);
        chk("addi_opcode", 64'(opcode),    64'h13);
        chk("addi_rd",     64'(rd),        64'd5);
        chk("addi_rs1",    64'(rs1),       64'd0);
        chk("addi_funct3", 64'(funct3),    64'd0);
        chk("addi_imm",    imm,            64'hFFFF_FFFF_FFFF_FFFD);
        chk("addi_pc",     64'(pc_out),    64'h04);
        out_ready = 1'b1;
        tick();
        chk("addi_drain", 64'(out_valid), 64'd0);

        // beq x1,x2,-8
        drive(1'b1, 32'hFE208CE3, 8'h08);
        tick();
        drive(1'b0, 32'h0, 8'h0);
        chk("beq_rs1", 64'(rs1), 64'd1);
        chk("beq_rs2", 64'(rs2), 64'd2);
        chk("beq_imm", imm,      64'hFFFF_FFFF_FFFF_FFF8);
        tick();

        for (int i = 0; i < 5; i++) begin
            drive(1'b1, imm_ins[i], 8'(i));
            tick();
            drive(1'b0, 32'h0, 8'h0);
            chk($sformatf("immtab%0d", i), imm, imm_exp[i]);
            tick();
        end
        chk("immtab_empty", 64'(out_valid), 64'd0);

        // back-to-back stream with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h00000013 | (32'(k) << 7), 8'(8'h20 + 4 * k));
            tick();
            chk($sformatf("strm%0d_pc", k),    64'(pc_out),    64'(8'h20 + 4 * k));
            chk($sformatf("strm%0d_rd", k),    64'(rd),        64'(k));
            chk($sformatf("strm%0d_ready", k), 64'(in_ready),  64'd1);
            chk($sformatf("strm%0d_valid", k), 64'(out_valid), 64'd1);
        end
        drive(1'b0, 32'h0, 8'h0);
        tick();
        chk("strm_end", 64'(out_valid), 64'd0);

        // backpressure: fill both entries, hold a third, then drain
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 8'h40);
        tick();
        chk("bp_ready1", 64'(in_ready), 64'd1);
        drive(1'b1, 32'h00200113, 8'h44);
        tick();
        chk("bp_ready2", 64'(in_ready), 64'd0);
        chk("bp_head2",  64'(pc_out),   64'h40);
        drive(1'b1, 32'h00300193, 8'h48);
        tick();
        chk("bp_hold_pc",    64'(pc_out),   64'h40);
        chk("bp_hold_ready", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1_pc",    64'(pc_out),   64'h44);
        chk("bp_drain1_ready", 64'(in_ready), 64'd1);
        tick();
        chk("bp_drain2_pc", 64'(pc_out), 64'h48);
        chk("bp_drain2_rd", 64'(rd),     64'd3);
        drive(1'b0, 32'h0, 8'h0);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // flush while TWO with in_valid high
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 8'h50);
        tick();
        drive(1'b1, 32'h00200113, 8'h54);
        tick();
        chk("fl_full", 64'(in_ready), 64'd0);
        drive(1'b1, 32'h00300193, 8'h58);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        chk("fl2_valid", 64'(out_valid), 64'd0);
        chk("fl2_instr", 64'(instr_out), 64'd0);
        chk("fl2_ready", 64'(in_ready),  64'd1);
        tick();
        chk("fl2_stay_empty", 64'(out_valid), 64'd0);

        // flush in ONE while an instruction is accepted: it is dropped
        drive(1'b1, 32'h00100093, 8'h60);
        tick();
        drive(1'b1, 32'h00500293, 8'h64);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 8'h0);
        chk("fl1_valid", 64'(out_valid), 64'd0);
        chk("fl1_pc",    64'(pc_out),    64'd0);
        tick();
        chk("fl1_dropped", 64'(out_valid), 64'd0);

        // reset mid-stream while in ONE, then resume
        out_ready = 1'b1;
        drive(1'b1, 32'h00700393, 8'h70);
        tick();
        chk("rs_one", 64'(out_valid), 64'd1);
        drive(1'b1, 32'h00800413, 8'h74);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rs_valid", 64'(out_valid), 64'd0);
        chk("rs_instr", 64'(instr_out), 64'd0);
        chk("rs_pc",    64'(pc_out),    64'd0);
        chk("rs_imm",   imm,            64'd0);
        chk("rs_ready", 64'(in_ready),  64'd1);
        drive(1'b1, 32'h00900493, 8'h78);
        tick();
        drive(1'b0, 32'h0, 8'h0);
        chk("rs_resume_pc", 64'(pc_out), 64'h78);
        chk("rs_resume_rd", 64'(rd),     64'd9);
        tick();
        chk("rs_resume_empty", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
